// File: rtl/alarm_fsm.sv
// Alarm clock keypad controller: tracks key entry, alarm display/set and time set,
// with an inactivity timeout that abandons a partially entered number.
module alarm_fsm #(
    parameter logic [3:0]  NOKEY        = 4'd10,
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic [3:0] key,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        StShowTime       = 3'd0,
        StKeyStored      = 3'd1,
        StKeyWaited      = 3'd2,
        StKeyEntry       = 3'd3,
        StShowAlarm      = 3'd4,
        StSetAlarmTime   = 3'd5,
        StSetCurrentTime = 3'd6,
        StIllegal        = 3'd7
    } state_e;

    localparam logic [3:0] CntMax = 4'(TIMEOUT_SECS - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       key_valid;
    logic       counting;
    logic       timeout;

    assign key_valid = (key < NOKEY);
    assign counting  = (state_q == StKeyWaited) || (state_q == StKeyEntry);
    assign timeout   = counting && one_second && (cnt_q == CntMax);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StShowTime;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StShowTime: begin
                if (alarm_button) begin
                    state_d = StShowAlarm;
                end else if (key_valid) begin
                    state_d = StKeyStored;
                end
            end
            StKeyStored: state_d = StKeyWaited;
            StKeyWaited: begin
                if (!key_valid) begin
                    state_d = StKeyEntry;
                end else if (timeout) begin
                    state_d = StShowTime;
                end
            end
            StKeyEntry: begin
                // A fresh key wins over a coincident timeout.
                if (alarm_button) begin
                    state_d = StSetAlarmTime;
                end else if (time_button) begin
                    state_d = StSetCurrentTime;
                end else if (key_valid) begin
                    state_d = StKeyStored;
                end else if (timeout) begin
                    state_d = StShowTime;
                end
            end
            StShowAlarm: begin
                if (!alarm_button) begin
                    state_d = StShowTime;
                end
            end
            StSetAlarmTime:   state_d = StShowTime;
            StSetCurrentTime: state_d = StShowTime;
            default:          state_d = StShowTime;
        endcase
    end

    // Count only while staying within the wait/entry pair; any other path clears it.
    always_comb begin
        cnt_d = 4'd0;
        if (counting && ((state_d == StKeyWaited) || (state_d == StKeyEntry))) begin
            cnt_d = cnt_q;
            if (one_second && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        show_new_time = 1'b0;
        show_alarm    = 1'b0;
        shift         = 1'b0;
        load_new_a    = 1'b0;
        load_new_c    = 1'b0;
        reset_count   = 1'b0;
        case (state_q)
            StKeyStored: begin
                show_new_time = 1'b1;
                shift         = 1'b1;
            end
            StKeyWaited:    show_new_time = 1'b1;
            StKeyEntry:     show_new_time = 1'b1;
            StShowAlarm:    show_alarm    = 1'b1;
            StSetAlarmTime: load_new_a    = 1'b1;
            StSetCurrentTime: begin
                load_new_c  = 1'b1;
                reset_count = 1'b1;
            end
            default: ;
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_alarm_fsm.sv
// Testbench for alarm_fsm: directed vector table, hand-written timeout/reset sequences,
// and randomized stimulus against a behavioural model.
module tb_alarm_fsm;

    localparam int NoKey   = 10;
    localparam int Timeout = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic [3:0] key = 4'd10;
    logic       show_new_time, show_alarm, shift, load_new_a, load_new_c, reset_count;
    logic [2:0] fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: state number per the published encoding, seconds of inactivity seen so far.
    int m_state = 0;
    int m_secs  = 0;

    alarm_fsm dut (
        .clock        (clock),
        .reset        (reset),
        .one_second   (one_second),
        .alarm_button (alarm_button),
        .time_button  (time_button),
        .key          (key),
        .show_new_time(show_new_time),
        .show_alarm   (show_alarm),
        .shift        (shift),
        .load_new_a   (load_new_a),
        .load_new_c   (load_new_c),
        .reset_count  (reset_count),
        .fsm_state    (fsm_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       a;
        logic       t;
        logic [3:0] k;
        logic       os;
        int         exp_state;
    } vec_t;

    // {show_new_time, show_alarm, shift, load_new_a, load_new_c, reset_count}
    function automatic logic [5:0] exp_outs(input int s);
        case (s)
            1:       return 6'b101000;
            2, 3:    return 6'b100000;
            4:       return 6'b010000;
            5:       return 6'b000100;
            6:       return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] act_outs();
        return {show_new_time, show_alarm, shift, load_new_a, load_new_c, reset_count};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit valid, in_entry, tmo;
        int ns;
        valid    = (int'(key) < NoKey);
        in_entry = (m_state == 2) || (m_state == 3);
        tmo      = in_entry && one_second && (m_secs >= Timeout - 1);
        ns       = 0;
        case (m_state)
            0: ns = alarm_button ? 4 : (valid ? 1 : 0);
            1: ns = 2;
            2: ns = !valid ? 3 : (tmo ? 0 : 2);
            3: ns = alarm_button ? 5 : time_button ? 6 : valid ? 1 : tmo ? 0 : 3;
            4: ns = alarm_button ? 4 : 0;
            default: ns = 0;
        endcase
        if (in_entry && (ns == 2 || ns == 3)) m_secs = m_secs + (one_second ? 1 : 0);
        else m_secs = 0;
        m_state = ns;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, int'(fsm_state), m_state);
        check({tag, "_outs"}, int'(act_outs()), int'(exp_outs(m_state)));
        check({tag, "_excl"},
              int'((show_new_time && show_alarm) || ($countones({shift, load_new_a, load_new_c}) > 1)),
              0);
    endtask

    task automatic cycle(input logic a, input logic t, input logic [3:0] k, input logic os,
                         input string tag);
        alarm_button = a;
        time_button  = t;
        key          = k;
        one_second   = os;
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        m_state = 0;
        m_secs  = 0;
        check_all("async_rst");
        @(negedge clock);
        alarm_button = 1'b0;
        time_button  = 1'b0;
        key          = 4'd10;
        one_second   = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic go_entry(input logic [3:0] k);
        cycle(0, 0, k, 0, "ge1");
        check("ge_stored", int'(fsm_state), 1);
        cycle(0, 0, 4'd10, 0, "ge2");
        cycle(0, 0, 4'd10, 0, "ge3");
        check("ge_entry", int'(fsm_state), 3);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{0, 0, 4'd3,  0, 1}, '{0, 0, 4'd3,  0, 2}, '{0, 0, 4'd10, 0, 3},
            '{0, 1, 4'd10, 0, 6}, '{0, 0, 4'd10, 0, 0},
            '{0, 0, 4'd5,  0, 1}, '{0, 0, 4'd10, 0, 2}, '{0, 0, 4'd10, 0, 3},
            '{1, 0, 4'd10, 0, 5}, '{1, 0, 4'd10, 0, 0}, '{1, 0, 4'd10, 0, 4},
            '{1, 1, 4'd2,  1, 4}, '{0, 0, 4'd10, 0, 0}, '{0, 0, 4'd12, 0, 0},
            '{0, 0, 4'd9,  0, 1}, '{0, 0, 4'd9,  0, 2}, '{0, 0, 4'd9,  0, 2},
            '{0, 0, 4'd15, 0, 3}, '{1, 1, 4'd10, 0, 5}, '{0, 0, 4'd10, 0, 0}
        };

        #1;
        check_all("in_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) cycle(0, 0, 4'd10, 0, "idle");
        check("idle_state", int'(fsm_state), 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].a, vecs[i].t, vecs[i].k, vecs[i].os, "vec");
            check($sformatf("vec%0d_state", i), int'(fsm_state), vecs[i].exp_state);
            check($sformatf("vec%0d_outs", i), int'(act_outs()),
                  int'(exp_outs(vecs[i].exp_state)));
        end

        // Full timeout out of entry, pulses separated by idle cycles.
        go_entry(4'd1);
        for (int i = 1; i <= Timeout; i++) begin
            cycle(0, 0, 4'd10, 1, "tmo");
            check($sformatf("tmo_pulse%0d", i), int'(fsm_state), (i < Timeout) ? 3 : 0);
            cycle(0, 0, 4'd10, 0, "tmo_gap");
        end

        // Key coincident with the final pulse is taken; counter must restart from zero.
        go_entry(4'd2);
        for (int i = 0; i < Timeout - 1; i++) cycle(0, 0, 4'd10, 1, "pre");
        check("pre_still_entry", int'(fsm_state), 3);
        cycle(0, 0, 4'd7, 1, "key_vs_tmo");
        check("key_vs_tmo_state", int'(fsm_state), 1);
        cycle(0, 0, 4'd10, 0, "rel1");
        cycle(0, 0, 4'd10, 0, "rel2");
        for (int i = 1; i <= Timeout; i++) begin
            cycle(0, 0, 4'd10, 1, "cleared");
            check($sformatf("cleared_pulse%0d", i), int'(fsm_state), (i < Timeout) ? 3 : 0);
        end

        // Held key times out of KEY_WAITED without another shift.
        cycle(0, 0, 4'd8, 0, "hold1");
        cycle(0, 0, 4'd8, 0, "hold2");
        for (int i = 1; i <= Timeout; i++) begin
            cycle(0, 0, 4'd8, 1, "hold_tmo");
            check($sformatf("hold_shift%0d", i), int'(shift), 0);
        end
        check("hold_tmo_state", int'(fsm_state), 0);
        cycle(0, 0, 4'd10, 0, "hold_rel");

        // Asynchronous reset from KEY_WAITED, then SHOW_TIME rules apply immediately.
        cycle(0, 0, 4'd4, 0, "w1");
        cycle(0, 0, 4'd4, 0, "w2");
        check("w_state", int'(fsm_state), 2);
        do_reset();
        check("rst_state", int'(fsm_state), 0);
        cycle(1, 0, 4'd10, 0, "post_rst");
        check("post_rst_state", int'(fsm_state), 4);
        cycle(0, 0, 4'd10, 0, "post_rst2");

        for (int i = 0; i < 3000; i++) begin
            logic       a, t, os;
            logic [3:0] k;
            a  = ($urandom_range(0, 19) == 0);
            t  = ($urandom_range(0, 19) == 0);
            os = ($urandom_range(0, 2) == 0);
            k  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 9))
                                              : 4'($urandom_range(10, 15));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(a, t, k, os, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_fsm.md
ALARM_FSM -- requirements
Module: alarm_fsm

Interface
REQ-001 Parameter: NOKEY, 4'd10, key code meaning "no key pressed"; any key value >= NOKEY SHALL be treated as no key.
REQ-002 Parameter: TIMEOUT_SECS, 10, count of one_second pulses with no key activity that SHALL abort key entry.
REQ-003 Port: clock  input  1  single system clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  reset is asynchronous and active-high.
REQ-005 Port: one_second  input  1  one-cycle-wide pulse, once per second, from the time generator.
REQ-006 Port: alarm_button  input  1  level, synchronised upstream; requests alarm display or alarm set.
REQ-007 Port: time_button  input  1  level, synchronised upstream; commits entered digits as current time.
REQ-008 Port: key  input  4  keypad value, 0-9 valid digit, >= NOKEY idle.
REQ-009 Port: show_new_time  output  1  drives the LCD driver's key-display select.
REQ-010 Port: show_alarm  output  1  drives the LCD driver's alarm-display select.
REQ-011 Port: shift  output  1  one-cycle strobe; key register shifts in current key.
REQ-012 Port: load_new_a  output  1  one-cycle strobe; alarm register loads key register.
REQ-013 Port: load_new_c  output  1  one-cycle strobe; time counter loads key register.
REQ-014 Port: reset_count  output  1  one-cycle strobe; clears seconds prescaler, asserted with load_new_c.
REQ-015 Port: fsm_state  output  3  current state encoding, debug/verification only.

Function
REQ-016 States and encodings SHALL be: SHOW_TIME 0, KEY_STORED 1, KEY_WAITED 2, KEY_ENTRY 3, SHOW_ALARM 4, SET_ALARM_TIME 5, SET_CURRENT_TIME 6; code 7 SHALL go to SHOW_TIME next cycle.
REQ-017 SHOW_TIME: alarm_button=1 -> SHOW_ALARM; else valid key -> KEY_STORED; else stay.
REQ-018 KEY_STORED: unconditionally -> KEY_WAITED after one cycle.
REQ-019 KEY_WAITED: key released (>= NOKEY) -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay.
REQ-020 KEY_ENTRY: priority alarm_button -> SET_ALARM_TIME, then time_button -> SET_CURRENT_TIME, then valid key -> KEY_STORED, then timeout -> SHOW_TIME; else stay.
REQ-021 SHOW_ALARM: alarm_button=0 -> SHOW_TIME; else stay; time_button and key ignored.
REQ-022 SET_ALARM_TIME and SET_CURRENT_TIME: unconditionally -> SHOW_TIME after one cycle.
REQ-023 Outputs SHALL be Moore, decoded from current state: show_new_time=1 in KEY_STORED/KEY_WAITED/KEY_ENTRY; show_alarm=1 in SHOW_ALARM; shift=1 in KEY_STORED; load_new_a=1 in SET_ALARM_TIME; load_new_c=1 and reset_count=1 in SET_CURRENT_TIME; all others 0.
REQ-024 show_new_time and show_alarm SHALL never be 1 simultaneously; at most one of shift/load_new_a/load_new_c SHALL be 1 in any cycle.
REQ-025 Timeout counter: 4-bit, increments on one_second while in KEY_WAITED or KEY_ENTRY, cleared in every other state, including on KEY_STORED entry.
REQ-026 timeout SHALL be (count == TIMEOUT_SECS-1) and one_second; counter SHALL NOT wrap, saturating at TIMEOUT_SECS-1.
REQ-027 A key held through KEY_STORED SHALL produce exactly one shift; a new shift requires release to KEY_ENTRY first.
REQ-028 Simultaneous timeout and valid key in KEY_ENTRY SHALL take the key (-> KEY_STORED).

Reset
REQ-029 reset=1 SHALL immediately force state SHOW_TIME, timeout counter 0, all strobe/select outputs 0, independent of clock.
REQ-030 reset asserted mid-entry SHALL abandon entry with no load_new_a/load_new_c strobe; first cycle after release evaluates SHOW_TIME transitions.

Verification
REQ-031 Reset, idle key=10 for 20 cycles -> fsm_state=0, all outputs 0.
REQ-032 From SHOW_TIME key=3 two cycles then key=10, then time_button=1 -> shift one cycle, show_new_time high through entry, load_new_c=reset_count=1 one cycle, back to state 0.
REQ-033 Enter digit 5, release, alarm_button=1 -> load_new_a=1 exactly one cycle, then SHOW_TIME; alarm_button still held -> SHOW_ALARM next cycle.
REQ-034 In KEY_ENTRY, no key, 10 one_second pulses -> return to SHOW_TIME on the 10th pulse, no load strobe; 9 pulses then key=7 -> KEY_STORED, counter 0.
REQ-035 alarm_button and time_button both 1 in KEY_ENTRY -> SET_ALARM_TIME only; reset asserted in KEY_WAITED -> state 0 asynchronously, no strobes.
